// File: rtl/serial_subtractor.sv
// Purpose : bit-serial unsigned subtractor, one full-subtractor cell with a registered borrow, LSB first.
// Latency : done pulses WIDTH cycles after the accepting edge; a new start is accepted WIDTH+2 edges apart.
// Backpr. : none; start is only sampled in IDLE and is silently dropped while busy (no queuing).
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           request, sampled only while idle
//   a, b, bin       minuend, subtrahend, borrow-in; captured on the accepting edge
//   busy            high from the accepting edge until the return to idle
//   done            one-cycle pulse; diff/bout valid
//   diff, bout      (a - b - bin) mod 2^WIDTH and borrow-out, held until the next completion
//   ser_bit         difference bit computed on the previous edge, qualified by ser_valid
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ser_bit,
    output logic             ser_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // operand shift registers: bit 0 is always the bit being processed
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // result shift register fills from the MSB, so after WIDTH shifts bit 0 lands at index 0
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    // full-subtractor cell
    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last_bit;
    logic             accept;

    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ br;
        // borrow when a<b at this bit, or when the bits are equal and a borrow ripples through
        br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_nxt  = {d_bit, res_sh[WIDTH-1:1]};
        last_bit = (cnt == LAST_BIT);
        accept   = (state == ST_IDLE) && start;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last_bit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            br     <= bin;
            cnt    <= '0;
        end else if (state == ST_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt;
            br     <= br_nxt;
            cnt    <= cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
        end else begin
            // busy mirrors the state we are entering, so it rises on the accepting edge
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state == ST_RUN) && last_bit;
            ser_valid <= (state == ST_RUN);
            if (state == ST_RUN) begin
                ser_bit <= d_bit;
            end
            // result outputs only move on the completion edge
            if ((state == ST_RUN) && last_bit) begin
                diff <= res_nxt;
                bout <= br_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        st8, st16;
    logic [15:0] a, b;
    logic        bin;

    logic        busy8, done8, bout8, ser_bit8, ser_valid8;
    logic [7:0]  diff8;
    logic        busy16, done16, bout16, ser_bit16, ser_valid16;
    logic [15:0] diff16;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (st8),
        .a        (a[7:0]),
        .b        (b[7:0]),
        .bin      (bin),
        .busy     (busy8),
        .done     (done8),
        .diff     (diff8),
        .bout     (bout8),
        .ser_bit  (ser_bit8),
        .ser_valid(ser_valid8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (st16),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .busy     (busy16),
        .done     (done16),
        .diff     (diff16),
        .bout     (bout16),
        .ser_bit  (ser_bit16),
        .ser_valid(ser_valid16)
    );

    int total = 0;
    int bad   = 0;

    // last completed {bout,diff} of each instance, used to check the hold behaviour
    logic [8:0]  prev8  = '0;
    logic [16:0] prev16 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // advance one clock; return 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // reference: subtract at WIDTH+1 bits, the top bit is the borrow-out
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - 9'(c);
    endfunction

    function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - 17'(c);
    endfunction

    // one complete 8-bit operation with cycle-exact checks of every output
    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
        logic [8:0] m;
        m   = ref8(ta, tb, tbin);
        a   = {8'h00, ta};
        b   = {8'h00, tb};
        bin = tbin;
        st8 = 1'b1;
        cyc();                              // edge 0: accepted
        st8 = 1'b0;
        a   = 16'($urandom);                // operands are free to change now
        b   = 16'($urandom);
        bin = 1'($urandom);
        chk("op_busy0", busy8, 1);
        chk("op_sv0", ser_valid8, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("op_busy", busy8, 1);
            chk("op_sv", ser_valid8, 1);
            chk("op_sbit", ser_bit8, m[k-1]);
            chk("op_done", done8, (k == 8));
            if (k < 8) chk("op_hold", {bout8, diff8}, prev8);
        end
        chk("op_diff", diff8, m[7:0]);
        chk("op_bout", bout8, m[8]);
        prev8 = m;
        cyc();                              // edge 9: back to idle
        chk("op_busy_end", busy8, 0);
        chk("op_done_end", done8, 0);
        chk("op_sv_end", ser_valid8, 0);
        chk("op_keep", {bout8, diff8}, prev8);
    endtask

    initial begin
        logic [8:0]  m8;
        logic [16:0] m16;
        logic [7:0]  s8;
        logic [15:0] s16;
        int          ndone;

        rst_n = 1'b0;
        st8   = 1'b0;
        st16  = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        cyc();
        cyc();
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_bout", bout8, 0);
        chk("rst_sbit", ser_bit8, 0);
        chk("rst_sv", ser_valid8, 0);
        chk("rst16", {busy16, done16, bout16, diff16, ser_valid16}, 0);
        rst_n = 1'b1;
        cyc();

        // directed cases
        do_op8(8'h00, 8'h00, 1'b0);
        do_op8(8'h05, 8'h03, 1'b1);
        do_op8(8'h03, 8'h05, 1'b0);
        do_op8(8'h00, 8'hFF, 1'b1);

        // start pulses at edges 3 and 9 of a running op are ignored
        a = 16'h0080; b = 16'h0001; bin = 1'b0;
        st8 = 1'b1;
        cyc();                              // edge 0
        ndone = 0;
        for (int k = 0; k <= 10; k++) begin
            st8 = (k == 2 || k == 8);       // sampled at edge k+1
            cyc();
            ndone += int'(done8);
            if (k + 1 == 10) chk("ign_busy10", busy8, 0);
        end
        st8 = 1'b0;
        chk("ign_ndone", ndone, 1);
        chk("ign_diff", diff8, 8'h7F);
        chk("ign_bout", bout8, 0);
        prev8 = 9'h07F;

        // start held high is re-accepted at edge WIDTH+2
        st8 = 1'b1;
        cyc();                              // edge 0
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (k == 8) chk("hold_done8", done8, 1);
        end
        chk("hold_busy9", busy8, 0);
        cyc();                              // edge 10
        chk("hold_busy10", busy8, 1);
        st8 = 1'b0;
        for (int k = 1; k <= 8; k++) cyc();
        chk("hold_done2", done8, 1);
        chk("hold_diff2", diff8, 8'h7F);
        cyc();

        // asynchronous reset in the middle of an operation
        a = 16'h0055; b = 16'h0011; bin = 1'b1;
        st8 = 1'b1;
        cyc();
        st8 = 1'b0;
        for (int k = 1; k <= 4; k++) cyc();
        rst_n = 1'b0;
        #1;
        chk("ar_busy", busy8, 0);
        chk("ar_done", done8, 0);
        chk("ar_diff", diff8, 0);
        chk("ar_bout", bout8, 0);
        chk("ar_sv", ser_valid8, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        prev8 = '0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            ndone += int'(done8);
        end
        chk("ar_nodone", ndone, 0);
        do_op8(8'h10, 8'h01, 1'b0);

        // random sweep, both widths side by side
        for (int i = 0; i < 1000; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            bin = 1'($urandom);
            m8  = ref8(a[7:0], b[7:0], bin);
            m16 = ref16(a, b, bin);
            st8  = 1'b1;
            st16 = 1'b1;
            cyc();
            st8  = 1'b0;
            st16 = 1'b0;
            a = 16'($urandom);
            b = 16'($urandom);
            s8  = '0;
            s16 = '0;
            for (int k = 1; k <= 17; k++) begin
                cyc();
                chk("r_sv8", ser_valid8, (k <= 8));
                chk("r_sv16", ser_valid16, (k <= 16));
                if (k <= 8)  s8[k-1]  = ser_bit8;
                if (k <= 16) s16[k-1] = ser_bit16;
                chk("r_done8", done8, (k == 8));
                chk("r_done16", done16, (k == 16));
                if (k < 8) chk("r_hold8", {bout8, diff8}, prev8);
                else       chk("r_res8", {bout8, diff8}, m8);
                if (k < 16) chk("r_hold16", {bout16, diff16}, prev16);
                else        chk("r_res16", {bout16, diff16}, m16);
            end
            chk("r_busy8", busy8, 0);
            chk("r_busy16", busy16, 0);
            chk("r_ser8", s8, m8[7:0]);
            chk("r_ser16", s16, m16[15:0]);
            prev8  = m8;
            prev16 = m16;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
